// File: rtl/execute_unit_scheduler.sv
// Execute-stage sequencer: ALU pass-through, mul/div and FPU issue/wait, CSR bubble, stall and flush.
// Optional watchdog on multi-cycle waits is enabled by defining EXEC_SCHED_TIMEOUT_EN.
module execute_unit_scheduler #(
  parameter int COUNTER_WIDTH = 32,
  parameter int MAX_LATENCY   = 64
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     inValid,
  input  logic [1:0]               inClass,
  input  logic                     flush,
  input  logic                     nextStall,
  input  logic                     mulDivDone,
  input  logic                     fpDone,
  output logic                     mulDivStart,
  output logic                     fpStart,
  output logic                     unitAbort,
  output logic                     prevStall,
  output logic                     outValid,
  output logic [1:0]               outSel,
  output logic [COUNTER_WIDTH-1:0] busyCycles,
  output logic                     timeout
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_MD  = 2'd1,
    S_WAIT_FP  = 2'd2,
    S_CSR_WAIT = 2'd3
  } state_t;

  state_t                   r_state;
  state_t                   w_nextState;
  logic                     r_outValid;
  logic [1:0]               r_outSel;
  logic [COUNTER_WIDTH-1:0] r_busyCycles;
  logic                     w_accept;
  logic                     w_inWait;
  logic                     w_done;
  logic                     w_expire;
  logic                     w_newResult;
  logic [1:0]               w_newSel;

  assign w_inWait = (r_state == S_WAIT_MD) || (r_state == S_WAIT_FP);
  assign w_done   = ((r_state == S_WAIT_MD) && mulDivDone) ||
                    ((r_state == S_WAIT_FP) && fpDone);

  // Combinational outputs are forced low while reset is held.
  assign prevStall   = rstN && ((r_state != S_IDLE) || (r_outValid && nextStall));
  assign w_accept    = rstN && inValid && !prevStall && !flush;
  assign mulDivStart = w_accept && (inClass == 2'd1);
  assign fpStart     = w_accept && (inClass == 2'd2);
  assign unitAbort   = rstN && ((flush && w_inWait) || w_expire);

`ifdef EXEC_SCHED_TIMEOUT_EN
  localparam int WAIT_W = $clog2(MAX_LATENCY) + 1;

  logic [WAIT_W-1:0] r_waitCnt;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_waitCnt <= '0;
    end else if (mulDivStart || fpStart) begin
      r_waitCnt <= '0;
    end else if (w_inWait) begin
      r_waitCnt <= r_waitCnt + 1'b1;
    end
  end

  // A done in the expiry cycle completes normally; flush takes the abort path instead.
  assign w_expire = rstN && w_inWait && !w_done && !flush &&
                    (r_waitCnt == WAIT_W'(MAX_LATENCY));
  assign timeout  = w_expire;
`else
  assign w_expire = 1'b0;
  assign timeout  = 1'b0;
`endif

  always_comb begin
    w_nextState = r_state;
    w_newResult = 1'b0;
    w_newSel    = 2'd0;
    if (flush) begin
      w_nextState = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (inClass)
              2'd0: begin
                w_newResult = 1'b1;
                w_newSel    = 2'd0;
              end
              2'd1:    w_nextState = S_WAIT_MD;
              2'd2:    w_nextState = S_WAIT_FP;
              default: w_nextState = S_CSR_WAIT;
            endcase
          end
        end
        S_WAIT_MD: begin
          if (mulDivDone) begin
            w_newResult = 1'b1;
            w_newSel    = 2'd1;
            w_nextState = S_IDLE;
          end else if (w_expire) begin
            w_nextState = S_IDLE;
          end
        end
        S_WAIT_FP: begin
          if (fpDone) begin
            w_newResult = 1'b1;
            w_newSel    = 2'd2;
            w_nextState = S_IDLE;
          end else if (w_expire) begin
            w_nextState = S_IDLE;
          end
        end
        default: begin
          w_newResult = 1'b1;
          w_newSel    = 2'd3;
          w_nextState = S_IDLE;
        end
      endcase
    end
  end

  // A new result may overwrite the register only when the old one is being consumed,
  // which the accept/stall rules already guarantee.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_state      <= S_IDLE;
      r_outValid   <= 1'b0;
      r_outSel     <= 2'd0;
      r_busyCycles <= '0;
    end else begin
      r_state <= w_nextState;
      if (flush) begin
        r_outValid <= 1'b0;
      end else if (w_newResult) begin
        r_outValid <= 1'b1;
        r_outSel   <= w_newSel;
      end else if (!nextStall) begin
        r_outValid <= 1'b0;
      end
      if ((r_state != S_IDLE) && (r_busyCycles != {COUNTER_WIDTH{1'b1}})) begin
        r_busyCycles <= r_busyCycles + 1'b1;
      end
    end
  end

  assign outValid   = r_outValid;
  assign outSel     = r_outSel;
  assign busyCycles = r_busyCycles;

endmodule

// File: tb/tb_execute_unit_scheduler.sv
// Randomized and directed bench for execute_unit_scheduler against a transaction-level model.
module tb_execute_unit_scheduler;

  localparam int MAX_LAT = 8;
`ifdef EXEC_SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        inValid = 1'b0;
  logic [1:0]  inClass = 2'd0;
  logic        flush = 1'b0;
  logic        nextStall = 1'b0;
  logic        mulDivDone = 1'b0;
  logic        fpDone = 1'b0;
  logic        mulDivStart, fpStart, unitAbort, prevStall, outValid, timeout;
  logic [1:0]  outSel;
  logic [31:0] busyCycles;

  int checkCount = 0;
  int errCount   = 0;

  // Model: which unit (0 none, 1 mul/div, 2 FPU, 3 CSR bubble) currently owns the stage.
  int     mOwner = 0;
  int     mWait = 0;
  bit     mOutValid = 0;
  int     mOutSel = 0;
  longint mBusyCnt = 0;

  bit lastAbort, lastPrev;
  int mdStarts = 0;

  execute_unit_scheduler #(.COUNTER_WIDTH(32), .MAX_LATENCY(MAX_LAT)) dut (
    .clk(clk), .rstN(rstN), .inValid(inValid), .inClass(inClass), .flush(flush),
    .nextStall(nextStall), .mulDivDone(mulDivDone), .fpDone(fpDone),
    .mulDivStart(mulDivStart), .fpStart(fpStart), .unitAbort(unitAbort),
    .prevStall(prevStall), .outValid(outValid), .outSel(outSel),
    .busyCycles(busyCycles), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit v, input int cls, input bit fl, input bit ns,
                               input bit md, input bit fp, input bit rn);
    bit     ePrev, eAcc, eDone, eExp, eAbort, res;
    int     rsel;
    inValid = v; inClass = 2'(cls); flush = fl; nextStall = ns;
    mulDivDone = md; fpDone = fp; rstN = rn;
    @(negedge clk);
    ePrev  = rn && (mOwner != 0 || (mOutValid && ns));
    eAcc   = rn && v && !ePrev && !fl;
    eDone  = (mOwner == 1 && md) || (mOwner == 2 && fp);
    eExp   = TO_EN && rn && (mOwner == 1 || mOwner == 2) && !eDone && !fl && mWait == MAX_LAT;
    eAbort = rn && ((fl && (mOwner == 1 || mOwner == 2)) || eExp);
    checkOutput("outValid", 64'(outValid), 64'(mOutValid));
    checkOutput("outSel", 64'(outSel), 64'(mOutSel));
    checkOutput("prevStall", 64'(prevStall), 64'(ePrev));
    checkOutput("mulDivStart", 64'(mulDivStart), 64'(eAcc && cls == 1));
    checkOutput("fpStart", 64'(fpStart), 64'(eAcc && cls == 2));
    checkOutput("unitAbort", 64'(unitAbort), 64'(eAbort));
    checkOutput("timeout", 64'(timeout), 64'(eExp));
    checkOutput("busyCycles", 64'(busyCycles), 64'(mBusyCnt));
    lastAbort = unitAbort;
    lastPrev  = prevStall;
    if (mulDivStart) mdStarts++;
    @(posedge clk);
    if (!rn) begin
      mOwner = 0; mWait = 0; mOutValid = 0; mOutSel = 0; mBusyCnt = 0;
    end else begin
      if (mOwner != 0 && mBusyCnt < 64'hFFFF_FFFF) mBusyCnt++;
      res = 0; rsel = 0;
      if (fl) mOwner = 0;
      else if (mOwner == 0) begin
        if (eAcc) begin
          if (cls == 0) begin res = 1; rsel = 0; end
          else begin mOwner = cls; mWait = 0; end
        end
      end else if (mOwner == 3) begin res = 1; rsel = 3; mOwner = 0; end
      else if (eDone) begin res = 1; rsel = mOwner; mOwner = 0; end
      else if (eExp) mOwner = 0;
      else mWait++;
      if (fl) mOutValid = 0;
      else if (res) begin mOutValid = 1; mOutSel = rsel; end
      else if (!ns) mOutValid = 0;
    end
    #1;
  endtask

  initial begin
    $display("[TB] start");
    // Reset, then a stream of four ALU ops.
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_outValid", 64'(outValid), 64'd0);
    checkOutput("rst_outSel", 64'(outSel), 64'd0);
    checkOutput("rst_busy", 64'(busyCycles), 64'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 1);
      checkOutput("alu_outValid", 64'(outValid), 64'd1);
      checkOutput("alu_prevStall", 64'(lastPrev), 64'd0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("alu_busy", 64'(busyCycles), 64'd0);

    // Mul/div with done five cycles after accept.
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    mdStarts = 0;
    applyStimulus(1, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 1);
    checkOutput("md_stallLast", 64'(lastPrev), 64'd1);
    checkOutput("md_outValid", 64'(outValid), 64'd1);
    checkOutput("md_outSel", 64'(outSel), 64'd1);
    checkOutput("md_busy", 64'(busyCycles), 64'd5);
    checkOutput("md_starts", 64'(mdStarts), 64'd1);

    // CSR result held through three stalled cycles.
    applyStimulus(1, 3, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("csr_outValid", 64'(outValid), 64'd1);
    checkOutput("csr_outSel", 64'(outSel), 64'd3);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 1, 0, 0, 1);
      checkOutput("csr_hold", 64'(outValid), 64'd1);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("csr_clear", 64'(outValid), 64'd0);

    // FP flushed in the same cycle its done arrives.
    applyStimulus(1, 2, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 1, 0, 0, 1, 1);
    checkOutput("fp_abort", 64'(lastAbort), 64'd1);
    checkOutput("fp_outValid", 64'(outValid), 64'd0);
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    checkOutput("fp_nextAccept", 64'(lastPrev), 64'd0);
    checkOutput("fp_nextValid", 64'(outValid), 64'd1);

    // Reset while waiting on mul/div.
    applyStimulus(1, 1, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("rstmd_abort", 64'(lastAbort), 64'd0);
    checkOutput("rstmd_busy", 64'(busyCycles), 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("rstmd_stall", 64'(lastPrev), 64'd0);

    // FP that never completes.
    applyStimulus(1, 2, 0, 0, 0, 0, 1);
    for (int i = 0; i < 2 * MAX_LAT + 4; i++) applyStimulus(1, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 1, 0, 0, 0, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
                    $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 63) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/execute_unit_scheduler.md
Name: execute_unit_scheduler

Overview:
- Sequences the execute stage of the in-order core. Single-cycle ALU ops pass straight through.
- Issues multi-cycle ops to the shared mul/div unit or the FPU and holds the pipeline until they finish.
- Handles the CSR serialization bubble, drives the execute-stage valid and result-source select, and honours downstream stall and flush.

Parameters:
- COUNTER_WIDTH, 32, width of the busyCycles performance counter.
- MAX_LATENCY, 64, cycle limit in WAIT_MD/WAIT_FP; used only with the optional feature; must be >= 2.

Ports:
- clk  in  1  core clock
- rstN  in  1  synchronous active-low reset
- inValid  in  1  register-read stage holds a valid op
- inClass  in  2  0=ALU, 1=MULDIV, 2=FP, 3=CSR
- flush  in  1  branch/trap redirect from a later stage; kills everything here
- nextStall  in  1  next stage cannot accept this cycle
- mulDivDone  in  1  mul/div result ready (unit holds it until next start)
- fpDone  in  1  FPU result ready (unit holds it until next start)
- mulDivStart  out  1  one-cycle start pulse to mul/div
- fpStart  out  1  one-cycle start pulse to FPU
- unitAbort  out  1  cancels the in-flight multi-cycle op
- prevStall  out  1  stall to the register-read stage
- outValid  out  1  execute-stage valid to the next stage
- outSel  out  2  result source: 0=ALU, 1=MULDIV, 2=FP, 3=CSR
- busyCycles  out  COUNTER_WIDTH  cycles spent outside IDLE
- timeout  out  1  watchdog pulse (optional feature)

Behaviour:
- clk and rstN: one clock; reset is synchronous, active-low.
- Reset (rstN=0 at a clk edge): state=IDLE, outValid=0, outSel=0, busyCycles=0, timeout=0. Combinational outputs are 0 while in reset.
- States: IDLE, WAIT_MD, WAIT_FP, CSR_WAIT.
- prevStall = (state!=IDLE) | (outValid & nextStall). Combinational.
- accept = inValid & !prevStall & !flush.
- mulDivStart = accept & inClass==1; fpStart = accept & inClass==2. Both combinational, in the accept cycle.
- IDLE:
  - accept ALU: outValid=1 and outSel=0 next cycle; stay IDLE.
  - accept MULDIV: go to WAIT_MD.
  - accept FP: go to WAIT_FP.
  - accept CSR: go to CSR_WAIT.
- WAIT_MD / WAIT_FP: on mulDivDone / fpDone, set outValid=1 and outSel=1 / 2 next cycle; go to IDLE. Done pulses arriving in any other state are ignored.
- CSR_WAIT: exactly one bubble cycle, then outValid=1, outSel=3; go to IDLE. Total CSR latency is 2 cycles from accept.
- outValid register:
  - Holds value and outSel while nextStall=1.
  - With nextStall=0 and no new result, clears to 0 next cycle.
  - A new result and consumption of the old one in the same cycle overwrites the register, giving back-to-back ALU at 1 op/cycle.
- flush, any state:
  - Next state IDLE, outValid=0, no accept.
  - unitAbort=1 combinationally if state is WAIT_MD or WAIT_FP.
  - flush beats a done arriving in the same cycle: the result is dropped.
  - flush beats nextStall: a held result is discarded.
- Reset mid-operation: return to IDLE; no unitAbort pulse. The units are reset by the same rstN.
- busyCycles: +1 on every cycle with state!=IDLE; saturates at all-ones, no wrap.

Optional Feature:
- Macro: EXEC_SCHED_TIMEOUT_EN.
- Defined:
  - A log2(MAX_LATENCY)+1-bit counter clears on entry to WAIT_MD/WAIT_FP and increments each wait cycle.
  - If it reaches MAX_LATENCY with no done: timeout=1 for one cycle, unitAbort=1 that cycle, go to IDLE, outValid stays 0.
  - Priority: a done in that same cycle wins, with normal completion and no timeout.
- Not defined: timeout is tied to 0 and no counter logic exists.

Test Plan:
- Reset then ALU stream: inValid=1, class=0 for 4 cycles, nextStall=0 -> outValid=1 on cycles 1-4, outSel=0, prevStall=0 throughout, busyCycles=0.
- MULDIV with mulDivDone 5 cycles after accept -> single mulDivStart pulse; prevStall=1 for 5 cycles; outValid=1, outSel=1 on the cycle after done; busyCycles=5.
- CSR accepted with nextStall=1 for 3 cycles after the result -> outValid rises 2 cycles after accept with outSel=3; held for 3 cycles; cleared the cycle after nextStall drops.
- FP in flight, flush and fpDone in the same cycle -> unitAbort=1, state IDLE, outValid stays 0, and the next ALU op is accepted the following cycle.
- rstN=0 asserted in WAIT_MD -> all outputs reset next cycle, unitAbort=0, busyCycles=0.
- With EXEC_SCHED_TIMEOUT_EN and MAX_LATENCY=8, FP never done -> timeout and unitAbort pulse 8 cycles after entry, IDLE, outValid=0. Without the macro: timeout stays 0 and the scheduler waits indefinitely.
